// File: rtl/bft_inject_arbiter_if.sv
// Injection-side bundle between NUM_REQ PE requesters, the arbiter and one
// BFT leaf interface port.
//
// Handshake: requester i offers a packet by raising req_valid[i] with
// req_data/req_last stable; the packet is taken on the rising clk edge where
// req_valid[i] & req_ready[i] are both high.  req_ready never depends on
// req_valid.  The leaf side sees a write whenever pe_interface MSB is 1, and
// raises resend while its FIFO is full, which blocks every write.
interface bft_inject_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int num_leaves = 2,
    parameter int payload_sz = 1
);
    localparam int DW   = $clog2(num_leaves) + payload_sz;
    localparam int P_SZ = DW + 1;
    localparam int GW   = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [P_SZ-1:0]       pe_interface;
    logic                  resend;
    logic [GW-1:0]         grant_id;
    logic                  busy;

    // Requesters plus leaf FIFO status, as seen from outside the arbiter.
    modport master (
        output req_valid, req_last, req_data, resend,
        input  req_ready, pe_interface, grant_id, busy
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_last, req_data, resend,
        output req_ready, pe_interface, grant_id, busy
    );
endinterface

// File: rtl/bft_inject_arbiter.sv
// Round-robin injection arbiter: shares one BFT leaf injection port among
// NUM_REQ requesters, granting bursts of up to MAX_BURST packets and
// prepending the valid bit.  No write is issued while resend is high.
module bft_inject_arbiter #(
    parameter int num_leaves = 2,
    parameter int payload_sz = 1,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bft_inject_arbiter_if.slave       bus
);
    localparam int DW   = $clog2(num_leaves) + payload_sz;
    localparam int p_sz = DW + 1;
    localparam int GW   = $clog2(NUM_REQ);
    localparam int BW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] RR_RST   = GW'(NUM_REQ - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]         state;
    logic [GW-1:0]      gnt;
    logic [GW-1:0]      rr_ptr;
    logic [BW-1:0]      beat_cnt;

    logic               sel_valid;
    logic               sel_last;
    logic [DW-1:0]      sel_data;
    logic               xfer;
    logic               release_now;
    logic [NUM_REQ-1:0] cand;
    logic [GW-1:0]      base;
    logic [GW-1:0]      idx;
    logic [GW-1:0]      pick;
    logic               pick_found;

    // Select the current grant holder's valid/last/data.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == GW'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Transfer, release decision and leaf-side outputs.
    always_comb begin
        xfer        = (state == ST_GRANT) && sel_valid && !bus.resend;
        release_now = !sel_valid || (xfer && (sel_last || beat_cnt == BEAT_MAX));
        bus.pe_interface = xfer ? {1'b1, sel_data} : '0;
        bus.grant_id     = gnt;
        // busy is the state register itself, so it doubles as FSM visibility.
        bus.busy         = (state == ST_GRANT);
        bus.req_ready    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = (state == ST_GRANT) && (gnt == GW'(i)) && !bus.resend;
        end
    end

    // Round-robin pick: search upward from rr_ptr; while granted, the current
    // holder is excluded so a release always moves on to someone else.
    always_comb begin
        cand = bus.req_valid;
        base = rr_ptr;
        if (state == ST_GRANT) begin
            base = gnt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt == GW'(i)) cand[i] = 1'b0;
            end
        end
        idx        = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(base) + k) % NUM_REQ);
            if (!pick_found && cand[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    // Grant FSM: IDLE arbitrates with one cycle latency; GRANT holds under
    // resend, counts beats, and hands over without a bubble when possible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            rr_ptr   <= RR_RST;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.req_valid) begin
                        state    <= ST_GRANT;
                        gnt      <= pick;
                        rr_ptr   <= pick;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    if (release_now) begin
                        if (pick_found) begin
                            gnt      <= pick;
                            rr_ptr   <= pick;
                            beat_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bft_inject_arbiter.sv
// Directed bench for bft_inject_arbiter: 4 requesters, bursts of 4,
// packets tagged {id, sequence} so order and loss are visible on the leaf port.
module tb_bft_inject_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int MAX_BURST  = 4;
    localparam int num_leaves = 4;
    localparam int payload_sz = 6;
    localparam int DW   = 8;
    localparam int P_SZ = 9;

    logic clk;
    logic rst_n;

    bft_inject_arbiter_if #(.NUM_REQ(NUM_REQ), .num_leaves(num_leaves), .payload_sz(payload_sz)) bus();

    bft_inject_arbiter #(
        .num_leaves(num_leaves), .payload_sz(payload_sz),
        .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // requester model state and scoreboard
    int               rem   [NUM_REQ];
    logic [5:0]       seq   [NUM_REQ];
    logic             lastm [NUM_REQ];
    logic [NUM_REQ-1:0] acc;
    logic [P_SZ-1:0]  exp_q [$];
    logic             rs_q  [$];
    logic             rn_q  [$];
    int               checks;
    int               errors;
    int               cyc;

    function automatic logic [P_SZ-1:0] g(input int id, input int s);
        g = {1'b1, 2'(id), 6'(s)};
    endfunction

    task automatic drive_req();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]          = (rem[i] > 0);
            bus.req_last[i]           = lastm[i];
            bus.req_data[i*DW +: DW]  = {2'(i), seq[i]};
        end
    endtask

    task automatic setup(input int r0, input int r1, input int r2, input int r3, input logic lm);
        rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
        for (int i = 0; i < NUM_REQ; i++) begin
            seq[i]   = '0;
            lastm[i] = lm;
        end
    endtask

    // One clock: apply accepted handshakes and new inputs just after the edge,
    // then stop on the falling edge where outputs are stable.
    task automatic step_cycle(input logic rs, input logic rn);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                seq[i] = seq[i] + 6'd1;
                rem[i] = rem[i] - 1;
            end
        end
        rst_n      = rn;
        bus.resend = rs;
        drive_req();
        @(negedge clk);
        acc = rst_n ? (bus.req_valid & bus.req_ready) : '0;
        cyc++;
    endtask

    task automatic push_v(input logic [P_SZ-1:0] e, input logic rs, input logic rn);
        exp_q.push_back(e);
        rs_q.push_back(rs);
        rn_q.push_back(rn);
    endtask

    task automatic test_reset();
        logic [P_SZ-1:0] e;
        for (int k = 0; k < 2; k++) begin
            step_cycle(1'b0, 1'b0);
            checks++;
            if (bus.pe_interface !== '0 || bus.req_ready !== '0 || bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
                errors++;
                $display("FAIL reset cyc%0d pe=%h ready=%b busy=%b gid=%0d expected 0/0/0/0",
                         cyc, bus.pe_interface, bus.req_ready, bus.busy, bus.grant_id);
            end
        end
        step_cycle(1'b0, 1'b1);
        checks++;
        if (bus.busy !== 1'b0 || bus.pe_interface !== '0) begin
            errors++;
            $display("FAIL reset_release cyc%0d busy=%b pe=%h expected 0/0", cyc, bus.busy, bus.pe_interface);
        end
        step_cycle(1'b0, 1'b1);
        checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0 || bus.pe_interface !== g(0, 0)) begin
            errors++;
            $display("FAIL first_grant cyc%0d busy=%b gid=%0d pe=%h expected 1/0/%h",
                     cyc, bus.busy, bus.grant_id, bus.pe_interface, g(0, 0));
        end
        push_v(g(1, 0), 0, 1); push_v(g(2, 0), 0, 1); push_v(g(3, 0), 0, 1); push_v('0, 0, 1);
        while (exp_q.size() != 0) begin
            step_cycle(rs_q.pop_front(), rn_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (bus.pe_interface !== e) begin
                errors++;
                $display("FAIL reset_drain cyc%0d pe=%h expected %h", cyc, bus.pe_interface, e);
            end
        end
    endtask

    task automatic test_fairness();
        logic [P_SZ-1:0] e;
        setup(3, 3, 3, 3, 1'b1);
        push_v('0, 0, 1);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NUM_REQ; i++) push_v(g(i, r), 0, 1);
        push_v('0, 0, 1);
        while (exp_q.size() != 0) begin
            step_cycle(rs_q.pop_front(), rn_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (bus.pe_interface !== e) begin
                errors++;
                $display("FAIL fairness cyc%0d pe=%h expected %h", cyc, bus.pe_interface, e);
            end
        end
    endtask

    task automatic test_burst_cap();
        logic [P_SZ-1:0] e;
        setup(0, 10, 4, 0, 1'b0);
        push_v('0, 0, 1);
        for (int s = 0; s < 4; s++) push_v(g(1, s), 0, 1);
        for (int s = 0; s < 4; s++) push_v(g(2, s), 0, 1);
        for (int s = 4; s < 8; s++) push_v(g(1, s), 0, 1);
        push_v('0, 0, 1);
        push_v(g(1, 8), 0, 1); push_v(g(1, 9), 0, 1);
        push_v('0, 0, 1); push_v('0, 0, 1);
        while (exp_q.size() != 0) begin
            step_cycle(rs_q.pop_front(), rn_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (bus.pe_interface !== e) begin
                errors++;
                $display("FAIL burst_cap cyc%0d pe=%h expected %h", cyc, bus.pe_interface, e);
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_cap_idle busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_backpressure();
        logic [P_SZ-1:0] e;
        logic rs;
        setup(6, 0, 0, 0, 1'b0);
        push_v('0, 0, 1); push_v(g(0, 0), 0, 1); push_v(g(0, 1), 0, 1);
        for (int k = 0; k < 5; k++) push_v('0, 1, 1);
        push_v(g(0, 2), 0, 1); push_v(g(0, 3), 0, 1); push_v('0, 0, 1);
        push_v(g(0, 4), 0, 1); push_v(g(0, 5), 0, 1); push_v('0, 0, 1); push_v('0, 0, 1);
        while (exp_q.size() != 0) begin
            rs = rs_q.pop_front();
            step_cycle(rs, rn_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (bus.pe_interface !== e) begin
                errors++;
                $display("FAIL backpressure cyc%0d pe=%h expected %h", cyc, bus.pe_interface, e);
            end
            if (rs) begin
                checks++;
                if (bus.req_ready !== '0 || bus.busy !== 1'b1 || bus.grant_id !== 2'd0) begin
                    errors++;
                    $display("FAIL backpressure_hold cyc%0d ready=%b busy=%b gid=%0d expected 0000/1/0",
                             cyc, bus.req_ready, bus.busy, bus.grant_id);
                end
            end
        end
    endtask

    task automatic test_forfeit();
        logic [P_SZ-1:0] e;
        setup(0, 2, 0, 2, 1'b0);
        push_v('0, 0, 1); push_v(g(1, 0), 0, 1); push_v(g(1, 1), 0, 1);
        for (int k = 0; k < 3; k++) begin
            step_cycle(rs_q.pop_front(), rn_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (bus.pe_interface !== e) begin
                errors++;
                $display("FAIL forfeit cyc%0d pe=%h expected %h", cyc, bus.pe_interface, e);
            end
        end
        step_cycle(1'b0, 1'b1);
        checks++;
        if (bus.pe_interface !== '0 || bus.busy !== 1'b1 || bus.grant_id !== 2'd1) begin
            errors++;
            $display("FAIL forfeit_drop cyc%0d pe=%h busy=%b gid=%0d expected 0/1/1",
                     cyc, bus.pe_interface, bus.busy, bus.grant_id);
        end
        step_cycle(1'b0, 1'b1);
        checks++;
        if (bus.pe_interface !== g(3, 0) || bus.grant_id !== 2'd3) begin
            errors++;
            $display("FAIL forfeit_move cyc%0d pe=%h gid=%0d expected %h/3",
                     cyc, bus.pe_interface, bus.grant_id, g(3, 0));
        end
        push_v(g(3, 1), 0, 1); push_v('0, 0, 1); push_v('0, 0, 1);
        while (exp_q.size() != 0) begin
            step_cycle(rs_q.pop_front(), rn_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (bus.pe_interface !== e) begin
                errors++;
                $display("FAIL forfeit_tail cyc%0d pe=%h expected %h", cyc, bus.pe_interface, e);
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL forfeit_idle busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [P_SZ-1:0] e;
        setup(0, 0, 10, 3, 1'b0);
        push_v('0, 0, 1); push_v(g(2, 0), 0, 1); push_v(g(2, 1), 0, 1);
        push_v('0, 1, 1); push_v('0, 1, 0);
        while (exp_q.size() != 0) begin
            step_cycle(rs_q.pop_front(), rn_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (bus.pe_interface !== e || bus.req_ready !== '0 && e === '0 && bus.resend) begin
                errors++;
                $display("FAIL reset_mid_pre cyc%0d pe=%h ready=%b expected %h", cyc, bus.pe_interface, bus.req_ready, e);
            end
        end
        step_cycle(1'b1, 1'b0);
        checks++;
        if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0 || bus.pe_interface !== '0) begin
            errors++;
            $display("FAIL reset_mid cyc%0d busy=%b gid=%0d pe=%h expected 0/0/0",
                     cyc, bus.busy, bus.grant_id, bus.pe_interface);
        end
        step_cycle(1'b0, 1'b1);
        checks++;
        if (bus.busy !== 1'b0 || bus.pe_interface !== '0) begin
            errors++;
            $display("FAIL reset_mid_release cyc%0d busy=%b pe=%h expected 0/0", cyc, bus.busy, bus.pe_interface);
        end
        step_cycle(1'b0, 1'b1);
        checks++;
        if (bus.grant_id !== 2'd2 || bus.pe_interface !== g(2, 2)) begin
            errors++;
            $display("FAIL reset_mid_regrant cyc%0d gid=%0d pe=%h expected 2/%h",
                     cyc, bus.grant_id, bus.pe_interface, g(2, 2));
        end
        for (int s = 3; s < 6; s++) push_v(g(2, s), 0, 1);
        for (int s = 0; s < 3; s++) push_v(g(3, s), 0, 1);
        push_v('0, 0, 1);
        for (int s = 6; s < 10; s++) push_v(g(2, s), 0, 1);
        push_v('0, 0, 1);
        while (exp_q.size() != 0) begin
            step_cycle(rs_q.pop_front(), rn_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (bus.pe_interface !== e) begin
                errors++;
                $display("FAIL reset_mid_tail cyc%0d pe=%h expected %h", cyc, bus.pe_interface, e);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        acc    = '0;
        rst_n  = 1'b0;
        bus.resend = 1'b0;
        setup(1, 1, 1, 1, 1'b1);
        drive_req();
        test_reset();
        test_fairness();
        test_burst_cap();
        test_backpressure();
        test_forfeit();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
